// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared definitions for the PC / instruction-fetch stage.
//   fetch_state_e     : fetch FSM state encodings (2 bits)
//   DEF_WIDTH         : default data/address width
//   DEF_RESET_VECTOR  : default PC value loaded on reset
package pc_fetch_pkg;

   localparam int          DEF_WIDTH        = 16;
   localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundle of the fetch stage's memory and downstream signals.
//   load/jump_addr                : redirect from the decode/ALU datapath
//   imem_req/imem_addr            : fetch request to instruction memory
//   imem_ack/imem_data            : memory response (data valid with ack)
//   instr/instr_valid/instr_ready : valid/ready hand-off to decode
//   pc                            : address of instr
// master = fetch stage, slave = its environment (memory + decode).
interface pc_fetch_if #(parameter int WIDTH = 16);
   logic             load;
   logic [WIDTH-1:0] jump_addr;
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ack;
   logic [WIDTH-1:0] imem_data;
   logic [WIDTH-1:0] instr;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] pc;

   modport master (
      input  load, jump_addr, imem_ack, imem_data, instr_ready,
      output imem_req, imem_addr, instr, instr_valid, pc
   );

   modport slave (
      output load, jump_addr, imem_ack, imem_data, instr_ready,
      input  imem_req, imem_addr, instr, instr_valid, pc
   );
endinterface

// File: rtl/pc_fetch_inc16.sv
// pc_fetch_inc16: combinational WIDTH-bit increment; carry out is dropped,
// so the all-ones value wraps to zero.
//   a : operand
//   y : a + 1 modulo 2^WIDTH
module pc_fetch_inc16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = a + WIDTH'(1);
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch stage of the 16-bit CPU.
// Fetches one word per instruction over a req/ack handshake and hands it to
// decode over valid/ready; accepts jump redirects from the datapath.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_fetch_if master (memory request/response, decode hand-off,
//           jump redirect, current pc)
// All outputs are registered.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter int               WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR)
) (
   input  logic         clk,
   input  logic         rst_n,
   pc_fetch_if.master   bus
);

   fetch_state_e     state;
   logic [WIDTH-1:0] pc_q, addr_q, instr_q, pc_inc, tgt;
   logic             req_q, valid_q;
   // Set when a jump lands while a request is still outstanding: the word
   // that eventually comes back belongs to the old stream and is dropped.
   logic             flush_q;

   pc_fetch_inc16 #(.WIDTH(WIDTH)) u_inc (.a(pc_q), .y(pc_inc));

   // Redirect target: a jump this cycle overrides the current pc.
   assign tgt = bus.load ? bus.jump_addr : pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc_q    <= RESET_VECTOR;
         addr_q  <= '0;
         instr_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pc_q   <= tgt;
               addr_q <= tgt;
               req_q  <= 1'b1;
               state  <= FETCH;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  if (flush_q || bus.load) begin
                     // stale word: reissue at the (possibly new) pc, req stays high
                     pc_q    <= tgt;
                     addr_q  <= tgt;
                     flush_q <= 1'b0;
                  end else begin
                     instr_q <= bus.imem_data;
                     valid_q <= 1'b1;
                     req_q   <= 1'b0;
                     state   <= HOLD;
                  end
               end else if (bus.load) begin
                  // address must stay stable until ack, so only pc moves now
                  pc_q    <= bus.jump_addr;
                  flush_q <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.load) begin
                  pc_q    <= bus.jump_addr;
                  addr_q  <= bus.jump_addr;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state   <= FETCH;
               end else if (bus.instr_ready) begin
                  pc_q    <= pc_inc;
                  addr_q  <= pc_inc;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state   <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized and directed stimulus for pc_fetch, checked each
// cycle against a transaction-level model of the fetch stage.
module tb_pc_fetch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_fetch_if #(.WIDTH(16)) bus ();

   pc_fetch #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state
   logic [15:0] m_pc, m_addr;
   logic        m_valid, m_req, m_flush, m_idle;

   // memory contents: bijective scramble so every address holds a distinct word
   function automatic logic [15:0] memfn(input logic [15:0] a);
      logic [15:0] p;
      p = a * 16'h9E37;
      return p ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_addr = 16'h0000;
      m_valid = 1'b0; m_req = 1'b0; m_flush = 1'b0; m_idle = 1'b1;
      bus.load = 1'b0; bus.jump_addr = '0; bus.imem_ack = 1'b0;
      bus.imem_data = '0; bus.instr_ready = 1'b0;
   endtask

   // Called at a falling edge: check outputs against the model, drive the
   // inputs for the coming rising edge, advance the model, wait one cycle.
   task automatic step(input logic ld, input logic [15:0] ja, input logic rdy,
                       input logic ak, input logic fdat, input logic [15:0] dat);
      logic [15:0] nxt;
      logic        was_valid;
      chk("pc", bus.pc, m_pc);
      chk("instr_valid", {15'd0, bus.instr_valid}, {15'd0, m_valid});
      chk("imem_req", {15'd0, bus.imem_req}, {15'd0, m_req});
      if (m_valid) chk("instr", bus.instr, memfn(m_pc));
      if (m_req)   chk("imem_addr", bus.imem_addr, m_addr);

      bus.load = ld; bus.jump_addr = ja; bus.instr_ready = rdy; bus.imem_ack = ak;
      bus.imem_data = fdat ? dat : (ak ? memfn(bus.imem_addr) : 16'($urandom));

      nxt = ld ? ja : m_pc;
      was_valid = m_valid;
      if (m_idle) begin
         m_req = 1'b1; m_addr = nxt; m_idle = 1'b0;
      end else if (m_valid) begin
         if (ld || rdy) begin
            m_valid = 1'b0; m_req = 1'b1;
            m_addr = ld ? ja : m_pc + 16'd1;
         end
      end else if (m_req) begin
         if (ak) begin
            if (ld || m_flush) m_addr = nxt;
            else begin m_valid = 1'b1; m_req = 1'b0; end
            m_flush = 1'b0;
         end else if (ld) m_flush = 1'b1;
      end
      if (ld) m_pc = ja;
      else if (was_valid && rdy) m_pc = m_pc + 16'd1;
      @(negedge clk);
   endtask

   // zero-wait memory until an instruction is held (bounded)
   task automatic wait_valid();
      for (int i = 0; i < 20 && !m_valid; i++) step(1'b0, 16'h0, 1'b0, m_req, 1'b0, 16'h0);
      if (!m_valid) chk("wait_valid_timeout", 16'd0, 16'd1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_req"},   {15'd0, bus.imem_req},    16'd0);
      chk({tag, "_addr"},  bus.imem_addr,            16'h0000);
      chk({tag, "_instr"}, bus.instr,                16'h0000);
      chk({tag, "_valid"}, {15'd0, bus.instr_valid}, 16'd0);
      chk({tag, "_pc"},    bus.pc,                   16'h0000);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // streaming with zero-wait memory and ready tied high
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, m_req, 1'b0, 16'h0);

      // stall 5 cycles in HOLD
      wait_valid();
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

      // jump in HOLD with ready also high: jump wins
      step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("jump_hold_addr", bus.imem_addr, 16'h1234);
      chk("jump_hold_pc", bus.pc, 16'h1234);

      // jump during an outstanding fetch; stale DEAD word must be discarded
      step(1'b1, 16'h0ABC, 1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'hDEAD);
      chk("flush_valid", {15'd0, bus.instr_valid}, 16'd0);
      chk("flush_readdr", bus.imem_addr, 16'h0ABC);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);

      // pc wrap at FFFF
      wait_valid();
      step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0);
      wait_valid();
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("wrap_addr", bus.imem_addr, 16'h0000);

      // async reset while a request is outstanding, then a late ack in IDLE
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, m_req, 1'b0, 16'h0);

      // randomized traffic: random acks (also outside FETCH), loads, stalls
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] ja;
         case ($urandom_range(0, 3))
            0:       ja = 16'hFFFF;
            1:       ja = 16'hFFFE;
            default: ja = 16'($urandom);
         endcase
         step($urandom_range(0, 9) == 0, ja, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) != 0, 1'b0, 16'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
